// File: rtl/adc_dac_pkg.sv
// Shared definitions for the ADC/DSP/DAC channel router: DAC source encodings,
// the shift-select width and the saturating left-shift helper.
package adc_dac_pkg;

  localparam int unsigned SHIFT_W = 3;

  localparam logic [1:0] SRC_ADC  = 2'd0;
  localparam logic [1:0] SRC_DSP  = 2'd1;
  localparam logic [1:0] SRC_HOST = 2'd2;
  localparam logic [1:0] SRC_RAMP = 2'd3;

  // Left-shift a sign-extended sample and clamp it to a signed w-bit range.
  function automatic logic [31:0] sat_shift(input logic [31:0] x,
                                            input logic [SHIFT_W-1:0] sh,
                                            input int unsigned w);
    logic signed [39:0] wide;
    logic signed [39:0] maxv;
    logic signed [39:0] minv;
    wide = $signed({{8{x[31]}}, x}) <<< sh;
    maxv = (40'sd1 <<< (w - 1)) - 40'sd1;
    minv = -(40'sd1 <<< (w - 1));
    if (wide > maxv) begin
      return maxv[31:0];
    end else if (wide < minv) begin
      return minv[31:0];
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/adc_dac_chan.sv
// One router channel: ADC offset-binary conversion, DSP zero-order hold,
// decimated valid/ready hold register with overrun, and the two-stage DAC path.
module adc_dac_chan
  import adc_dac_pkg::*;
#(
  parameter int unsigned ADC_W = 12,
  parameter int unsigned DAC_W = 14,
  parameter int unsigned DSP_W = 16
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [ADC_W-1:0]   adc_data,
  output logic [DSP_W-1:0]   dsp_in,
  input  logic [DSP_W-1:0]   dsp_out,
  input  logic               dsp_ce,
  output logic [DSP_W-1:0]   dec_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               overrun,
  input  logic               overrun_clr,
  input  logic [DSP_W-1:0]   host_data,
  input  logic [1:0]         ch_src,
  input  logic [SHIFT_W-1:0] ch_shift,
  input  logic [DSP_W-1:0]   ramp,
  output logic [DAC_W-1:0]   dac_data
);

  localparam logic [DAC_W-1:0] MID = DAC_W'(1) << (DAC_W - 1);

  logic [DSP_W-1:0] dsp_in_q, dsp_in_d;
  logic [DSP_W-1:0] hold_q, hold_d;
  logic [DSP_W-1:0] dec_data_q, dec_data_d;
  logic             dec_valid_q, dec_valid_d;
  logic             ovr_q, ovr_d;
  logic [DSP_W-1:0] s_q, s_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic signed [ADC_W-1:0] tc;
  logic [DSP_W-1:0] sel;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dsp_in_q    <= '0;
      hold_q      <= '0;
      dec_data_q  <= '0;
      dec_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      s_q         <= '0;
      dac_q       <= MID;
    end else begin
      dsp_in_q    <= dsp_in_d;
      hold_q      <= hold_d;
      dec_data_q  <= dec_data_d;
      dec_valid_q <= dec_valid_d;
      ovr_q       <= ovr_d;
      s_q         <= s_d;
      dac_q       <= dac_d;
    end
  end

  always_comb begin
    tc          = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    dsp_in_d    = DSP_W'(tc);
    hold_d      = hold_q;
    dec_data_d  = dec_data_q;
    dec_valid_d = dec_valid_q;
    ovr_d       = ovr_q;
    sel         = '0;

    if (dsp_ce) begin
      hold_d = dsp_out;
    end

    // Clear first so a same-cycle overrun set wins.
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (dec_valid_q && dec_ready) begin
      dec_valid_d = 1'b0;
    end
    if (dsp_ce) begin
      dec_data_d  = dsp_out;
      dec_valid_d = 1'b1;
      if (dec_valid_q && !dec_ready) begin
        ovr_d = 1'b1;
      end
    end

    case (ch_src)
      SRC_ADC:  sel = DSP_W'(dsp_in_q << (DSP_W - ADC_W));
      SRC_DSP:  sel = hold_q;
      SRC_HOST: sel = host_data;
      SRC_RAMP: sel = ramp;
      default:  sel = '0;
    endcase

    s_d   = DSP_W'(sat_shift(32'(signed'(sel)), ch_shift, DSP_W));
    dac_d = s_q[DSP_W-1 -: DAC_W] ^ MID;
  end

  assign dsp_in    = dsp_in_q;
  assign dec_data  = dec_data_q;
  assign dec_valid = dec_valid_q;
  assign overrun   = ovr_q;
  assign dac_data  = dac_q;

endmodule

// File: rtl/adc_dac_chan_router.sv
// N-channel ADC/DSP/DAC router top: shared test ramp and per-channel instances.
// Optional feature macro: ADC_DAC_RAMP_EN (ramp counter present when defined).
module adc_dac_chan_router
  import adc_dac_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned ADC_W     = 12,
  parameter int unsigned DAC_W     = 14,
  parameter int unsigned DSP_W     = 16,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [NCH*ADC_W-1:0]   adc_data,
  output logic [NCH*DSP_W-1:0]   dsp_in,
  input  logic [NCH*DSP_W-1:0]   dsp_out,
  input  logic [NCH-1:0]         dsp_ce,
  output logic [NCH*DSP_W-1:0]   dec_data,
  output logic [NCH-1:0]         dec_valid,
  input  logic [NCH-1:0]         dec_ready,
  output logic [NCH-1:0]         overrun,
  input  logic                   overrun_clr,
  input  logic [NCH*DSP_W-1:0]   host_data,
  input  logic [NCH*2-1:0]       ch_src,
  input  logic [NCH*SHIFT_W-1:0] ch_shift,
  output logic [NCH*DAC_W-1:0]   dac_data
);

  logic [DSP_W-1:0] ramp_w;

`ifdef ADC_DAC_RAMP_EN
  logic [DSP_W-1:0] ramp_q, ramp_d;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  always_comb begin
    ramp_d = ramp_q + DSP_W'(RAMP_STEP);
  end

  assign ramp_w = ramp_q;
`else
  // No counter: source 3 reads zero, i.e. a midscale DAC word.
  assign ramp_w = DSP_W'(RAMP_STEP) & DSP_W'(0);
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    adc_dac_chan #(
      .ADC_W (ADC_W),
      .DAC_W (DAC_W),
      .DSP_W (DSP_W)
    ) u_chan (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .adc_data    (adc_data[c*ADC_W +: ADC_W]),
      .dsp_in      (dsp_in[c*DSP_W +: DSP_W]),
      .dsp_out     (dsp_out[c*DSP_W +: DSP_W]),
      .dsp_ce      (dsp_ce[c]),
      .dec_data    (dec_data[c*DSP_W +: DSP_W]),
      .dec_valid   (dec_valid[c]),
      .dec_ready   (dec_ready[c]),
      .overrun     (overrun[c]),
      .overrun_clr (overrun_clr),
      .host_data   (host_data[c*DSP_W +: DSP_W]),
      .ch_src      (ch_src[c*2 +: 2]),
      .ch_shift    (ch_shift[c*SHIFT_W +: SHIFT_W]),
      .ramp        (ramp_w),
      .dac_data    (dac_data[c*DAC_W +: DAC_W])
    );
  end

endmodule
